// File: rtl/seg_to_binary.sv
// Seven-segment readback: decodes DIGITS active-high segment patterns to BCD,
// then converts the BCD value to unsigned binary by serial reverse double-dabble.
module seg_to_binary #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*DIGITS-1:0]   I_seg,
  output logic                  busy,
  output logic                  O_valid,
  output logic                  O_err,
  output logic [BIN_W-1:0]      O_bin
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Returns {valid, digit}; the dp bit is masked before matching.
  function automatic logic [4:0] seg_decode(input logic [7:0] seg);
    logic [4:0] res;
    case (seg & 8'hFE)
      8'hFC:   res = 5'h10;
      8'h60:   res = 5'h11;
      8'hDA:   res = 5'h12;
      8'hF2:   res = 5'h13;
      8'h66:   res = 5'h14;
      8'hB6:   res = 5'h15;
      8'hBE:   res = 5'h16;
      8'hE4:   res = 5'h17;
      8'hFE:   res = 5'h18;
      8'hF6:   res = 5'h19;
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  // Post-shift correction: any digit that picked up the 8-weight from above drops by 3.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd8) begin
        res[4*i +: 4] = bcd[4*i +: 4] - 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

  state_t               state_r, state_next_s;
  logic [8*DIGITS-1:0]  seg_r, seg_next_s;
  logic [BCD_W-1:0]     bcd_r, bcd_next_s, bcd_dec_s, bcd_shift_s;
  logic [BIN_W-1:0]     bin_r, bin_next_s, bin_shift_s;
  logic [CNT_W-1:0]     cnt_r, cnt_next_s;
  logic                 err_r, err_next_s, bad_s;
  logic                 busy_r, o_valid_r, o_err_r;
  logic [BIN_W-1:0]     o_bin_r;

  // Decode every captured byte and flag any unrecognised pattern.
  always_comb begin
    bcd_dec_s = {BCD_W{1'b0}};
    bad_s     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      logic [4:0] dec;
      dec = seg_decode(seg_r[8*i +: 8]);
      bcd_dec_s[4*i +: 4] = dec[3:0];
      bad_s = bad_s | ~dec[4];
    end
  end

  // One step of {bcd, bin} >> 1 followed by digit correction.
  always_comb begin
    bin_shift_s = {bcd_r[0], bin_r[BIN_W-1:1]};
    bcd_shift_s = bcd_adjust({1'b0, bcd_r[BCD_W-1:1]});
  end

  // Next-state and datapath update.
  always_comb begin
    state_next_s = state_r;
    seg_next_s   = seg_r;
    bcd_next_s   = bcd_r;
    bin_next_s   = bin_r;
    cnt_next_s   = cnt_r;
    err_next_s   = err_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          seg_next_s   = I_seg;
          state_next_s = DECODE;
        end else begin
          state_next_s = IDLE;
        end
      end
      DECODE: begin
        bcd_next_s = bcd_dec_s;
        bin_next_s = {BIN_W{1'b0}};
        cnt_next_s = CNT_W'(BIN_W);
        err_next_s = bad_s;
        if (bad_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      SHIFT: begin
        bcd_next_s = bcd_shift_s;
        bin_next_s = bin_shift_s;
        cnt_next_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, datapath and output registers; outputs load on entry to DONE so
  // O_bin/O_err are already valid during the O_valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      seg_r     <= {(8*DIGITS){1'b0}};
      bcd_r     <= {BCD_W{1'b0}};
      bin_r     <= {BIN_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      o_valid_r <= 1'b0;
      o_err_r   <= 1'b0;
      o_bin_r   <= {BIN_W{1'b0}};
    end else begin
      state_r   <= state_next_s;
      seg_r     <= seg_next_s;
      bcd_r     <= bcd_next_s;
      bin_r     <= bin_next_s;
      cnt_r     <= cnt_next_s;
      err_r     <= err_next_s;
      busy_r    <= (state_next_s != IDLE);
      o_valid_r <= (state_next_s == DONE);
      if (state_next_s == DONE) begin
        o_bin_r <= bin_next_s;
        o_err_r <= err_next_s;
      end else begin
        o_bin_r <= o_bin_r;
        o_err_r <= o_err_r;
      end
    end
  end

  assign busy    = busy_r;
  assign O_valid = o_valid_r;
  assign O_err   = o_err_r;
  assign O_bin   = o_bin_r;

endmodule

// File: tb/tb_seg_to_binary.sv
// Directed bench for seg_to_binary: latency, results, error path, busy-start
// rejection and mid-conversion reset.
module tb_seg_to_binary;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] I_seg;
  logic        busy;
  logic        O_valid;
  logic        O_err;
  logic [6:0]  O_bin;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] seg_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                               8'hB6, 8'hBE, 8'hE4, 8'hFE, 8'hF6};

  seg_to_binary #(.DIGITS(2), .BIN_W(7)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .I_seg   (I_seg),
    .busy    (busy),
    .O_valid (O_valid),
    .O_err   (O_err),
    .O_bin   (O_bin)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Latency is counted so that the capture edge k gives cycle k+1 as the first sample.
  task automatic run_conv(input string tag, input logic [15:0] seg, input int exp_bin,
                          input logic exp_err, input int exp_lat);
    int m;
    int busy_n;
    I_seg = seg;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    I_seg = 16'h0000;
    m = 0;
    busy_n = 0;
    while (O_valid !== 1'b1 && m < 20) begin
      if (busy === 1'b1) busy_n++;
      @(posedge clk); #1;
      m++;
    end
    if (busy === 1'b1) busy_n++;
    check({tag, " latency"}, m + 1, exp_lat);
    check({tag, " busy cycles"}, busy_n, exp_lat);
    check({tag, " bin"}, {25'd0, O_bin}, exp_bin);
    check({tag, " err"}, {31'd0, O_err}, {31'd0, exp_err});
    @(posedge clk); #1;
    check({tag, " valid drop"}, {31'd0, O_valid}, 32'd0);
    check({tag, " busy drop"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int valid_n;
    int got;
    rst   = 1'b1;
    start = 1'b0;
    I_seg = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",  {31'd0, busy},    32'd0);
    check("reset valid", {31'd0, O_valid}, 32'd0);
    check("reset err",   {31'd0, O_err},   32'd0);
    check("reset bin",   {25'd0, O_bin},   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_conv("c15", 16'h60B6, 15, 1'b0, 9);
    run_conv("c99", 16'hF6F6, 99, 1'b0, 9);
    repeat (3) @(posedge clk);
    #1;
    check("hold bin", {25'd0, O_bin}, 32'd99);
    run_conv("c00", 16'hFCFC, 0, 1'b0, 9);
    run_conv("dp07", 16'hFDE5, 7, 1'b0, 9);
    run_conv("blank", 16'h6000, 0, 1'b1, 2);
    run_conv("clear err", 16'h60B6, 15, 1'b0, 9);

    for (int d1 = 0; d1 < 10; d1++) begin
      for (int d0 = 0; d0 < 10; d0++) begin
        run_conv($sformatf("sweep%0d%0d", d1, d0), {seg_tab[d1], seg_tab[d0]},
                 10 * d1 + d0, 1'b0, 9);
      end
    end

    // "42" with extra start pulses while busy and new input "88".
    I_seg = 16'h66DA;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    I_seg = 16'hFEFE;
    valid_n = 0;
    got = -1;
    for (int c = 2; c <= 14; c++) begin
      start = (c == 3 || c == 5) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      if (O_valid === 1'b1) begin
        valid_n++;
        got = int'(O_bin);
      end
    end
    start = 1'b0;
    check("busy start pulses", valid_n, 1);
    check("busy start bin", got, 42);

    // Reset asserted during the fourth SHIFT cycle.
    I_seg = 16'h60B6;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid rst busy",  {31'd0, busy},    32'd0);
    check("mid rst bin",   {25'd0, O_bin},   32'd0);
    check("mid rst valid", {31'd0, O_valid}, 32'd0);
    valid_n = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (O_valid === 1'b1) valid_n++;
    end
    check("mid rst no valid", valid_n, 0);
    run_conv("after rst", 16'h60B6, 15, 1'b0, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
